// File: rtl/led_mode_mux.sv
// led_mode_mux: registered OFF/SCORE/BLINK/CHASE LED output stage driven by one prescaled tick.
// Define LED_DIM_EN to add a 4-bit PWM that dims SCORE mode to DIM_LEVEL/16 duty.
module led_mode_mux #(
    parameter int WIDTH     = 7,
    parameter int TICK_DIV  = 25000000,
    parameter int DIM_LEVEL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       led_control,
    input  logic [WIDTH-1:0] score,
    output logic             tick,
    output logic [WIDTH-1:0] leds_out
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int PW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] TOP = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_ONE = PW'(1);
    localparam logic [WIDTH-1:0] BIT0 = WIDTH'(1);

    logic [CW-1:0]    cnt;
    logic [PW-1:0]    pos, nxt_pos;
    logic [1:0]       mode;
    logic             phase, dir, nxt_phase, nxt_dir, chg, tick_i, step;
    logic [WIDTH-1:0] score_led, nxt_leds;

`ifdef LED_DIM_EN
    logic [3:0] pwm;
    always_ff @(posedge clk)
        if (rst) pwm <= '0;
        else     pwm <= pwm + 4'd1;
    assign score_led = ({1'b0, pwm} < 5'(DIM_LEVEL)) ? score : '0;
`else
    assign score_led = score;
`endif

    // a mode change restarts every animation and swallows a coincident tick
    always_comb begin
        chg       = led_control != mode;
        tick_i    = (cnt == LAST) && !chg;
        step      = tick_i && (mode == 2'b11);
        nxt_phase = chg | (phase ^ (tick_i && (mode == 2'b10)));
        nxt_pos   = chg ? '0 : !step ? pos : dir ? pos - POS_ONE : pos + POS_ONE;
        nxt_dir   = chg ? 1'b0 : !step ? dir : dir ? (pos != POS_ONE) : (pos + POS_ONE == TOP);
        nxt_leds  = led_control == 2'b00 ? '0 :
                    led_control == 2'b01 ? score_led :
                    led_control == 2'b10 ? (nxt_phase ? score : '0) :
                    BIT0 << nxt_pos;
    end

    always_ff @(posedge clk)
        if (rst) begin
            cnt      <= '0;
            phase    <= 1'b1;
            pos      <= '0;
            dir      <= 1'b0;
            mode     <= 2'b00;
            tick     <= 1'b0;
            leds_out <= '0;
        end else begin
            cnt      <= (chg || cnt == LAST) ? '0 : cnt + CNT_ONE;
            phase    <= nxt_phase;
            pos      <= nxt_pos;
            dir      <= nxt_dir;
            mode     <= led_control;
            tick     <= tick_i;
            leds_out <= nxt_leds;
        end
endmodule

// File: tb/tb_led_mode_mux.sv
// tb_led_mode_mux: randomized and directed checks of led_mode_mux against a cycle-count reference model.
module tb_led_mode_mux;
    localparam int W  = 7;
    localparam int TD = 4;
    localparam int DL = 8;

    logic         clk = 0;
    logic         rst = 1;
    logic [1:0]   led_control = 0;
    logic [W-1:0] score = 0;
    logic         tick;
    logic [W-1:0] leds_out;

    int checks = 0;
    int errors = 0;

    int m_mode = 0, n = 0, p = 0;
    logic [W-1:0] exp_leds = 0;
    logic         exp_tick = 0;

    led_mode_mux #(.WIDTH(W), .TICK_DIV(TD), .DIM_LEVEL(DL)) dut (
        .clk(clk), .rst(rst), .led_control(led_control), .score(score),
        .tick(tick), .leds_out(leds_out)
    );

    always #5 clk = ~clk;

    // Model: n counts cycles since mode entry; every animation is a function of n alone.
    task automatic step();
        int t, k, ps;
        bit ph, dim_on;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; n = 0; p = 0; exp_leds = '0; exp_tick = 0;
        end else begin
            if (int'(led_control) != m_mode) begin m_mode = int'(led_control); n = 0; end
            else n++;
            t  = n / TD;
            k  = t % (2 * (W - 1));
            ps = k < W ? k : 2 * (W - 1) - k;
            ph = (t % 2) == 0;
`ifdef LED_DIM_EN
            dim_on = p < DL;
`else
            dim_on = 1;
`endif
            exp_tick = n > 0 && n % TD == 0;
            case (m_mode)
                0: exp_leds = '0;
                1: exp_leds = dim_on ? score : '0;
                2: exp_leds = ph ? score : '0;
                default: exp_leds = W'(1) << ps;
            endcase
            p = (p + 1) % 16;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; led_control = 2'b01; score = 7'b0001000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (leds_out !== 7'd0) begin errors++; $display("FAIL reset_leds got=%h want=00", leds_out); end
            checks++;
            if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick); end
        end
        rst = 0;
        step();
        checks++;
        if (leds_out !== 7'b0001000) begin errors++; $display("FAIL score_first got=%h want=08", leds_out); end
        score = 7'b0011100;
        step();
        checks++;
        if (leds_out !== 7'b0011100) begin errors++; $display("FAIL score_update got=%h want=1c", leds_out); end
    endtask

    task automatic test_blink();
        led_control = 2'b00; step();
        led_control = 2'b10; score = 7'h7F;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (leds_out !== exp_leds) begin errors++; $display("FAIL blink_leds cyc=%0d got=%h want=%h", i, leds_out, exp_leds); end
            checks++;
            if (tick !== exp_tick) begin errors++; $display("FAIL blink_tick cyc=%0d got=%b want=%b", i, tick, exp_tick); end
        end
    endtask

    task automatic test_chase();
        int seq [13] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0};
        logic [W-1:0] want;
        led_control = 2'b00; step();
        led_control = 2'b11;
        for (int i = 0; i < 12 * TD + 1; i++) begin
            score = W'($urandom);
            step();
            checks++;
            if (leds_out !== exp_leds) begin errors++; $display("FAIL chase_leds cyc=%0d got=%h want=%h", i, leds_out, exp_leds); end
            if (i % TD == 0) begin
                want = W'(1) << seq[i / TD];
                checks++;
                if (leds_out !== want) begin errors++; $display("FAIL chase_seq tick=%0d got=%h want=%h", i / TD, leds_out, want); end
            end
        end
    endtask

    task automatic test_mode_change();
        logic [W-1:0] s;
        led_control = 2'b00; step();
        led_control = 2'b11;
        for (int i = 0; i < 4 * TD; i++) step();
        checks++;
        if (leds_out !== 7'b0001000) begin errors++; $display("FAIL mc_pos3 got=%h want=08", leds_out); end
        s = W'($urandom) | W'(1);
        led_control = 2'b10; score = s;
        step();
        checks++;
        if (leds_out !== s) begin errors++; $display("FAIL mc_first got=%h want=%h", leds_out, s); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL mc_tick got=%b want=0", tick); end
        for (int i = 1; i < TD; i++) begin
            step();
            checks++;
            if (leds_out !== s) begin errors++; $display("FAIL mc_on cyc=%0d got=%h want=%h", i, leds_out, s); end
        end
        step();
        checks++;
        if (leds_out !== 7'd0) begin errors++; $display("FAIL mc_off got=%h want=00", leds_out); end
        led_control = 2'b11;
        step();
        checks++;
        if (leds_out !== 7'd1) begin errors++; $display("FAIL mc_rechase got=%h want=01", leds_out); end
    endtask

    task automatic test_reset_mid_chase();
        led_control = 2'b00; step();
        led_control = 2'b11;
        for (int i = 0; i < 5 * TD + 2; i++) step();
        checks++;
        if (leds_out !== 7'b0100000) begin errors++; $display("FAIL rmc_pos5 got=%h want=20", leds_out); end
        rst = 1; step();
        checks++;
        if (leds_out !== 7'd0) begin errors++; $display("FAIL rmc_reset got=%h want=00", leds_out); end
        rst = 0;
        for (int i = 0; i < TD; i++) begin
            step();
            checks++;
            if (leds_out !== 7'd1) begin errors++; $display("FAIL rmc_bit0 cyc=%0d got=%h want=01", i, leds_out); end
        end
        step();
        checks++;
        if (leds_out !== 7'd2) begin errors++; $display("FAIL rmc_bit1 got=%h want=02", leds_out); end
    endtask

    task automatic test_dim();
        led_control = 2'b00; step();
        led_control = 2'b01; score = 7'h55;
        for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if (leds_out !== exp_leds) begin errors++; $display("FAIL dim_leds cyc=%0d got=%h want=%h", i, leds_out, exp_leds); end
`ifndef LED_DIM_EN
            checks++;
            if (leds_out !== 7'h55) begin errors++; $display("FAIL solid_score cyc=%0d got=%h want=55", i, leds_out); end
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            score = W'($urandom);
            if ($urandom_range(0, 11) == 0) led_control = 2'($urandom);
            rst = $urandom_range(0, 79) == 0;
            step();
            checks++;
            if (leds_out !== exp_leds) begin errors++; $display("FAIL rand_leds cyc=%0d got=%h want=%h", i, leds_out, exp_leds); end
            checks++;
            if (tick !== exp_tick) begin errors++; $display("FAIL rand_tick cyc=%0d got=%b want=%b", i, tick, exp_tick); end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_blink();
        test_chase();
        test_mode_change();
        test_reset_mid_chase();
        test_dim();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
